// File: rtl/player_motion_ctrl_pkg.sv
// Shared game constants and the jump state encoding used by the player motion logic.
package player_motion_ctrl_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CALC_W  = 11;
    localparam int unsigned VEL_W   = 5;

    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_PLAYER_W = 32;
    localparam int unsigned DEF_GROUND_Y = 400;
    localparam int unsigned DEF_X_INIT   = 304;
    localparam int unsigned DEF_H_SPEED  = 4;
    localparam int unsigned DEF_JUMP_V   = 12;
    localparam int unsigned DEF_GRAVITY  = 1;
    localparam int unsigned DEF_MAX_FALL = 15;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } motion_state_e;

endpackage

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: horizontal walk with screen clamping plus a GROUND/RISE/FALL
// jump FSM; position, state and the update strobe change one cycle after an accepted tick.
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned PLAYER_W = DEF_PLAYER_W,
    parameter int unsigned GROUND_Y = DEF_GROUND_Y,
    parameter int unsigned X_INIT   = DEF_X_INIT,
    parameter int unsigned H_SPEED  = DEF_H_SPEED,
    parameter int unsigned JUMP_V   = DEF_JUMP_V,
    parameter int unsigned GRAVITY  = DEF_GRAVITY,
    parameter int unsigned MAX_FALL = DEF_MAX_FALL
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               frame_tick_i,
    input  logic               enable_i,
    input  logic               btn_left_i,
    input  logic               btn_right_i,
    input  logic               btn_jump_i,
    output logic [COORD_W-1:0] player_x_o,
    output logic [COORD_W-1:0] player_y_o,
    output logic               airborne_o,
    output logic               pos_valid_o
);

    localparam logic [CALC_W-1:0] X_MAX_C    = CALC_W'(SCREEN_W - PLAYER_W);
    localparam logic [CALC_W-1:0] H_SPEED_C  = CALC_W'(H_SPEED);
    localparam logic [CALC_W-1:0] GROUND_Y_C = CALC_W'(GROUND_Y);
    localparam logic [CALC_W-1:0] JUMP_V_C   = CALC_W'(JUMP_V);
    localparam logic [CALC_W-1:0] GRAVITY_C  = CALC_W'(GRAVITY);
    localparam logic [CALC_W-1:0] MAX_FALL_C = CALC_W'(MAX_FALL);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [VEL_W-1:0]   vel_q, vel_d;
    motion_state_e      state_q, state_d;
    logic               jump_prev_q;
    logic               jump_pend_q, jump_pend_d;
    logic               pos_valid_q;

    logic              tick_acc;
    logic              jump_edge;
    logic              jump_now;
    logic [CALC_W-1:0] x_ext, y_ext, vel_ext;
    logic [CALC_W-1:0] x_new, y_new, vel_new;
    logic [CALC_W-1:0] fall_sum, fall_v;

    assign tick_acc  = frame_tick_i & enable_i;
    assign jump_edge = btn_jump_i & ~jump_prev_q;
    // A press landing in the tick cycle itself is honoured by that tick.
    assign jump_now  = jump_pend_q | jump_edge;

    assign x_ext    = {{(CALC_W-COORD_W){1'b0}}, x_q};
    assign y_ext    = {{(CALC_W-COORD_W){1'b0}}, y_q};
    assign vel_ext  = {{(CALC_W-VEL_W){1'b0}}, vel_q};
    assign fall_sum = vel_ext + GRAVITY_C;
    assign fall_v   = (fall_sum > MAX_FALL_C) ? MAX_FALL_C : fall_sum;

    always_comb begin
        x_new = x_ext;
        if (btn_left_i && !btn_right_i) begin
            x_new = (x_ext < H_SPEED_C) ? '0 : x_ext - H_SPEED_C;
        end else if (btn_right_i && !btn_left_i) begin
            x_new = (x_ext + H_SPEED_C > X_MAX_C) ? X_MAX_C : x_ext + H_SPEED_C;
        end

        y_new   = y_ext;
        vel_new = vel_ext;
        state_d = state_q;
        case (state_q)
            GROUND: begin
                if (jump_now) begin
                    y_new   = y_ext - JUMP_V_C;
                    vel_new = JUMP_V_C - GRAVITY_C;
                    state_d = RISE;
                end
            end
            RISE: begin
                if (vel_q == '0) begin
                    state_d = FALL;
                end else if (y_ext < vel_ext) begin
                    y_new   = '0;
                    vel_new = '0;
                    state_d = FALL;
                end else begin
                    y_new   = y_ext - vel_ext;
                    vel_new = (vel_ext < GRAVITY_C) ? '0 : vel_ext - GRAVITY_C;
                end
            end
            FALL: begin
                if (y_ext + fall_v >= GROUND_Y_C) begin
                    y_new   = GROUND_Y_C;
                    vel_new = '0;
                    state_d = GROUND;
                end else begin
                    y_new   = y_ext + fall_v;
                    vel_new = fall_v;
                end
            end
            default: begin
                y_new   = GROUND_Y_C;
                vel_new = '0;
                state_d = GROUND;
            end
        endcase

        x_d   = x_new[COORD_W-1:0];
        y_d   = y_new[COORD_W-1:0];
        vel_d = vel_new[VEL_W-1:0];

        // Every accepted tick drops the pending press, used or not, so airborne presses never queue.
        jump_pend_d = jump_pend_q;
        if (tick_acc) begin
            jump_pend_d = 1'b0;
        end else if (jump_edge) begin
            jump_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q         <= COORD_W'(X_INIT);
            y_q         <= COORD_W'(GROUND_Y);
            vel_q       <= '0;
            state_q     <= GROUND;
            jump_prev_q <= 1'b0;
            jump_pend_q <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            jump_prev_q <= btn_jump_i;
            jump_pend_q <= jump_pend_d;
            pos_valid_q <= tick_acc;
            if (tick_acc) begin
                x_q     <= x_d;
                y_q     <= y_d;
                vel_q   <= vel_d;
                state_q <= state_d;
            end
        end
    end

    assign player_x_o  = x_q;
    assign player_y_o  = y_q;
    assign airborne_o  = (state_q != GROUND);
    assign pos_valid_o = pos_valid_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: walking, clamping, enable gating, the full jump arc
// and asynchronous reset, each scenario checked against hand-computed positions.
module tb_player_motion_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       frame_tick_i = 1'b0;
    logic       enable_i = 1'b1;
    logic       btn_left_i = 1'b0;
    logic       btn_right_i = 1'b0;
    logic       btn_jump_i = 1'b0;
    logic [9:0] player_x_o;
    logic [9:0] player_y_o;
    logic       airborne_o;
    logic       pos_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    // y after each tick of a jump from the ground: rises 12,11,..,1 (apex 322 at tick 12),
    // tick 13 turns to FALL in place, then falls 1,2,..,12 and touches 400 at tick 25.
    int jump_y [25] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322, 322,
                        323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

    player_motion_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .frame_tick_i (frame_tick_i),
        .enable_i     (enable_i),
        .btn_left_i   (btn_left_i),
        .btn_right_i  (btn_right_i),
        .btn_jump_i   (btn_jump_i),
        .player_x_o   (player_x_o),
        .player_y_o   (player_y_o),
        .airborne_o   (airborne_o),
        .pos_valid_o  (pos_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // One-cycle tick; returns on the falling edge right after the sampling edge.
    task automatic do_tick(input logic with_jump);
        @(negedge clk_i);
        frame_tick_i = 1'b1;
        if (with_jump) btn_jump_i = 1'b1;
        @(negedge clk_i);
        frame_tick_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (player_x_o !== 10'd304) begin n_err++; $display("FAIL reset_x got %0d want 304", player_x_o); end
        n_cmp++;
        if (player_y_o !== 10'd400) begin n_err++; $display("FAIL reset_y got %0d want 400", player_y_o); end
        n_cmp++;
        if (airborne_o !== 1'b0) begin n_err++; $display("FAIL reset_airborne got %b want 0", airborne_o); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (pos_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_no_pulse cyc %0d got %b want 0", i, pos_valid_o); end
        end
        $display("test_reset: x=%0d y=%0d air=%b", player_x_o, player_y_o, airborne_o);
    endtask

    task automatic test_right_walk();
        btn_right_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (pos_valid_o !== 1'b1) begin n_err++; $display("FAIL walk_pulse tick %0d got %b want 1", k, pos_valid_o); end
            n_cmp++;
            if (player_x_o !== 10'(304 + 4 * k)) begin n_err++; $display("FAIL walk_x tick %0d got %0d want %0d", k, player_x_o, 304 + 4 * k); end
            @(negedge clk_i);
            n_cmp++;
            if (pos_valid_o !== 1'b0) begin n_err++; $display("FAIL walk_pulse_end tick %0d got %b want 0", k, pos_valid_o); end
            $display("test_right_walk: tick %0d x=%0d", k, player_x_o);
        end
        btn_right_i = 1'b0;
    endtask

    task automatic test_both_and_enable();
        btn_left_i  = 1'b1;
        btn_right_i = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (player_x_o !== 10'd316) begin n_err++; $display("FAIL both_x tick %0d got %0d want 316", k, player_x_o); end
        end
        btn_left_i = 1'b0;
        enable_i   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (pos_valid_o !== 1'b0) begin n_err++; $display("FAIL disabled_pulse tick %0d got %b want 0", k, pos_valid_o); end
            n_cmp++;
            if (player_x_o !== 10'd316 || player_y_o !== 10'd400) begin
                n_err++; $display("FAIL disabled_pos tick %0d got %0d,%0d want 316,400", k, player_x_o, player_y_o);
            end
        end
        btn_right_i = 1'b0;
        enable_i    = 1'b1;
        $display("test_both_and_enable: x=%0d y=%0d", player_x_o, player_y_o);
    endtask

    task automatic test_clamp();
        btn_right_i = 1'b1;
        repeat (72) do_tick(1'b0);
        n_cmp++;
        if (player_x_o !== 10'd604) begin n_err++; $display("FAIL clamp_pre_right got %0d want 604", player_x_o); end
        do_tick(1'b0);
        n_cmp++;
        if (player_x_o !== 10'd608) begin n_err++; $display("FAIL clamp_right1 got %0d want 608", player_x_o); end
        do_tick(1'b0);
        n_cmp++;
        if (player_x_o !== 10'd608) begin n_err++; $display("FAIL clamp_right2 got %0d want 608", player_x_o); end
        btn_right_i = 1'b0;
        btn_left_i  = 1'b1;
        repeat (151) do_tick(1'b0);
        n_cmp++;
        if (player_x_o !== 10'd4) begin n_err++; $display("FAIL clamp_pre_left got %0d want 4", player_x_o); end
        do_tick(1'b0);
        n_cmp++;
        if (player_x_o !== 10'd0) begin n_err++; $display("FAIL clamp_left1 got %0d want 0", player_x_o); end
        do_tick(1'b0);
        n_cmp++;
        if (player_x_o !== 10'd0) begin n_err++; $display("FAIL clamp_left2 got %0d want 0", player_x_o); end
        btn_left_i = 1'b0;
        $display("test_clamp: x=%0d", player_x_o);
    endtask

    // Jump pressed in the tick cycle while walking right from x=0.
    task automatic test_jump_arc();
        btn_right_i = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            do_tick(k == 1);
            if (k == 2) btn_jump_i = 1'b0;
            n_cmp++;
            if (player_y_o !== 10'(jump_y[k-1])) begin n_err++; $display("FAIL jump_y tick %0d got %0d want %0d", k, player_y_o, jump_y[k-1]); end
            n_cmp++;
            if (airborne_o !== (k < 25)) begin n_err++; $display("FAIL jump_air tick %0d got %b want %b", k, airborne_o, k < 25); end
            n_cmp++;
            if (player_x_o !== 10'(4 * k)) begin n_err++; $display("FAIL jump_x tick %0d got %0d want %0d", k, player_x_o, 4 * k); end
            $display("test_jump_arc: tick %0d x=%0d y=%0d air=%b", k, player_x_o, player_y_o, airborne_o);
        end
        btn_right_i = 1'b0;
    endtask

    // Press between ticks (pending path), then keep holding through the landing.
    task automatic test_jump_held();
        @(negedge clk_i);
        btn_jump_i = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int k = 1; k <= 28; k++) begin
            do_tick(1'b0);
            n_cmp++;
            if (player_y_o !== 10'((k <= 25) ? jump_y[k-1] : 400)) begin
                n_err++; $display("FAIL held_y tick %0d got %0d want %0d", k, player_y_o, (k <= 25) ? jump_y[k-1] : 400);
            end
            n_cmp++;
            if (airborne_o !== (k < 25)) begin n_err++; $display("FAIL held_air tick %0d got %b want %b", k, airborne_o, k < 25); end
        end
        btn_jump_i = 1'b0;
        $display("test_jump_held: y=%0d air=%b", player_y_o, airborne_o);
    endtask

    task automatic test_reset_mid_rise();
        for (int k = 1; k <= 5; k++) begin
            do_tick(k == 1);
            if (k == 1) btn_jump_i = 1'b0;
        end
        n_cmp++;
        if (player_y_o !== 10'd350 || airborne_o !== 1'b1) begin
            n_err++; $display("FAIL midrise_pre got y=%0d air=%b want 350,1", player_y_o, airborne_o);
        end
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (player_y_o !== 10'd400) begin n_err++; $display("FAIL async_reset_y got %0d want 400", player_y_o); end
        n_cmp++;
        if (airborne_o !== 1'b0) begin n_err++; $display("FAIL async_reset_air got %b want 0", airborne_o); end
        n_cmp++;
        if (player_x_o !== 10'd304) begin n_err++; $display("FAIL async_reset_x got %0d want 304", player_x_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_tick(1'b0);
        n_cmp++;
        if (player_y_o !== 10'd400 || airborne_o !== 1'b0) begin
            n_err++; $display("FAIL post_reset_tick got y=%0d air=%b want 400,0", player_y_o, airborne_o);
        end
        $display("test_reset_mid_rise: x=%0d y=%0d air=%b", player_x_o, player_y_o, airborne_o);
    endtask

    initial begin
        test_reset();
        test_right_walk();
        test_both_and_enable();
        test_clamp();
        test_jump_arc();
        test_jump_held();
        test_reset_mid_rise();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
